// File: rtl/multiply_divide_unit_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the HI/LO multiply/divide unit.
package multiply_divide_unit_pkg;

  localparam int MDU_OP_WIDTH = 4;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_NOP  = 4'd0;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MUL  = 4'd1;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULU = 4'd2;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIV  = 4'd3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIVU = 4'd4;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTHI = 4'd5;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTLO = 4'd6;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MFHI = 4'd7;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MFLO = 4'd8;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_RUN  = 2'd1,
    MDU_ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic mdu_is_iter(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_MUL) || (op == MDU_OP_MULU) ||
           (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic mdu_is_op(input logic [MDU_OP_WIDTH-1:0] op);
    return (op >= MDU_OP_MUL) && (op <= MDU_OP_MFLO);
  endfunction

endpackage

// File: rtl/multiply_divide_unit_shift_subtract_step.sv
// One restoring-division iteration: shift the next dividend bit in, subtract the divisor if it fits.
module shift_subtract_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  msb_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  qbit_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  assign shifted = {rem_i, msb_i};
  assign diff    = shifted - {1'b0, divisor_i};

  // Partial remainder stays below the divisor, so the top bit of diff is a clean borrow flag.
  assign qbit_o = ~diff[DATA_WIDTH];
  assign rem_o  = qbit_o ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/multiply_divide_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO pair.
module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [MDU_OP_WIDTH-1:0] op,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  output logic [DATA_WIDTH-1:0]   rd,
  output logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  function automatic logic [W-1:0] negate_if(input logic [W-1:0] x, input logic neg);
    return neg ? (~x + W'(1)) : x;
  endfunction

  function automatic logic [2*W-1:0] negate_wide_if(input logic [2*W-1:0] x, input logic neg);
    return neg ? (~x + (2*W)'(1)) : x;
  endfunction

  mdu_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;

  logic [2*W-1:0]  acc_q;
  logic [2*W-1:0]  acc_d;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    rs_q;
  logic            is_div_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            dz_q;

  logic            accept;
  logic            op_signed;
  logic            sign_a;
  logic            sign_b;
  logic [W:0]      mul_sum;
  logic [W-1:0]    div_rem;
  logic            div_qbit;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    hi_fix;
  logic [W-1:0]    lo_fix;

  assign accept    = (state_q == MDU_ST_IDLE) && en && !flush && mdu_is_iter(op);
  assign op_signed = (op == MDU_OP_MUL) || (op == MDU_OP_DIV);
  assign sign_a    = op_signed & rs[W-1];
  assign sign_b    = op_signed & rt[W-1];

  shift_subtract_step #(.DATA_WIDTH(W)) u_step (
    .rem_i     (acc_q[2*W-1:W]),
    .msb_i     (acc_q[W-1]),
    .divisor_i (opb_q),
    .rem_o     (div_rem),
    .qbit_o    (div_qbit)
  );

  // Multiply keeps the product high half above the shrinking multiplier; divide keeps {remainder, dividend/quotient}.
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};

  always_comb begin
    acc_d = acc_q;
    if (is_div_q) begin
      acc_d = {div_rem, acc_q[W-2:0], div_qbit};
    end else if (acc_q[0]) begin
      acc_d = {mul_sum, acc_q[W-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[2*W-1:1]};
    end
  end

  always_comb begin
    prod   = negate_wide_if(acc_q, neg_q_q);
    hi_fix = prod[2*W-1:W];
    lo_fix = prod[W-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        hi_fix = rs_q;
        lo_fix = '1;
      end else begin
        hi_fix = negate_if(acc_q[2*W-1:W], neg_r_q);
        lo_fix = negate_if(acc_q[W-1:0], neg_q_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= {{W{1'b0}}, negate_if(rs, sign_a)};
      opb_q    <= negate_if(rt, sign_b);
      rs_q     <= rs;
      is_div_q <= (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
      neg_q_q  <= sign_a ^ sign_b;
      neg_r_q  <= sign_a;
      dz_q     <= (rt == '0);
    end else if (state_q == MDU_ST_RUN) begin
      acc_q <= acc_d;
    end
  end

  // Flush overrides everything, including an accept or MTHI/MTLO in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= MDU_ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          MDU_ST_IDLE: begin
            if (en) begin
              if (mdu_is_iter(op)) begin
                state_q <= MDU_ST_RUN;
                cnt_q   <= CW'(W);
                busy_q  <= 1'b1;
              end else if (op == MDU_OP_MTHI) begin
                hi_q <= rs;
              end else if (op == MDU_OP_MTLO) begin
                lo_q <= rs;
              end
            end
          end
          MDU_ST_RUN: begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= MDU_ST_FIX;
            end
          end
          MDU_ST_FIX: begin
            hi_q    <= hi_fix;
            lo_q    <= lo_fix;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= MDU_ST_IDLE;
          end
          default: state_q <= MDU_ST_IDLE;
        endcase
      end
    end
  end

  assign stall = busy_q & en & mdu_is_op(op);

  always_comb begin
    rd = '0;
    if (en && (state_q == MDU_ST_IDLE)) begin
      if (op == MDU_OP_MFHI) begin
        rd = hi_q;
      end else if (op == MDU_OP_MFLO) begin
        rd = lo_q;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Randomised and directed checks of the multiply/divide unit against a plain-arithmetic HI/LO model.
module tb_multiply_divide_unit;
  import multiply_divide_unit_pkg::*;

  localparam int W = 32;

  logic                    clk;
  logic                    rst_n;
  logic                    en;
  logic [MDU_OP_WIDTH-1:0] op;
  logic                    flush;
  logic [W-1:0]            rs;
  logic [W-1:0]            rt;
  logic [W-1:0]            rd;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic [W-1:0]            hi;
  logic [W-1:0]            lo;

  int n_pass = 0;
  int n_chk  = 0;
  logic [W-1:0] m_hi, m_lo;

  multiply_divide_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .flush(flush),
    .rs(rs), .rt(rt), .rd(rd), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: {HI, LO} straight from signed/unsigned 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (o)
      MDU_OP_MUL:  r = 64'(sa * sb);
      MDU_OP_MULU: r = ua * ub;
      MDU_OP_DIV:  if (b == 0) r = {a, 32'hFFFF_FFFF};
                   else r = {32'(sa % sb), 32'(sa / sb)};
      MDU_OP_DIVU: if (b == 0) r = {a, 32'hFFFF_FFFF};
                   else r = {32'(ua % ub), 32'(ua / ub)};
      default:     r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    en = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    en = 1'b0; op = MDU_OP_NOP;
    #1;
  endtask

  // Issues at the current cycle; returns in the done cycle (DATA_WIDTH+2) without advancing.
  task automatic run_iter(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int bad;
    exp = ref_result(o, a, b);
    issue(o, a, b);
    bad = 0;
    for (int c = 1; c <= W + 1; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("busy_window", 64'(bad), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_clear", 64'(busy), 64'd0);
    check("hi_result", 64'(hi), 64'(exp[63:32]));
    check("lo_result", 64'(lo), 64'(exp[31:0]));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic [63:0] exp;
    int n, bad, sel;
    rst_n = 1'b0; en = 1'b0; op = MDU_OP_NOP; flush = 1'b0; rs = '0; rt = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    en = 1'b1; op = MDU_OP_MFHI; #1;
    check("mfhi_after_rst", 64'(rd), 64'd0);
    en = 1'b0; op = MDU_OP_NOP;
    @(negedge clk);

    // Directed arithmetic cases
    run_iter(MDU_OP_MUL, 32'hFFFF_FFFD, 32'd7);
    check("mul_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mul_lo_const", 64'(lo), 64'hFFFF_FFEB);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    run_iter(MDU_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulu_hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("mulu_lo_const", 64'(lo), 64'h0000_0001);
    run_iter(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_iter(MDU_OP_DIVU, 32'd7, 32'd0);
    check("divz_lo_const", 64'(lo), 64'hFFFF_FFFF);
    check("divz_hi_const", 64'(hi), 64'd7);
    run_iter(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo_const", 64'(lo), 64'h8000_0000);
    check("ovf_hi_const", 64'(hi), 64'd0);
    run_iter(MDU_OP_DIV, 32'd9, 32'd0);

    // MFLO held behind a divide
    issue(MDU_OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    en = 1'b1; op = MDU_OP_MFLO; #1;
    bad = 0;
    for (int c = 2; c <= W + 1; c++) begin
      if (stall !== 1'b1 || rd !== '0) bad++;
      @(negedge clk);
    end
    check("mflo_stall_window", 64'(bad), 64'd0);
    check("mflo_stall_release", 64'(stall), 64'd0);
    check("mflo_rd_new", 64'(rd), 64'd14);
    check("mflo_done", 64'(done), 64'd1);
    en = 1'b0; op = MDU_OP_NOP;
    m_hi = 32'd2; m_lo = 32'd14;

    // MTHI issued while busy lands after the divide
    issue(MDU_OP_DIV, 32'd100, 32'd7);
    en = 1'b1; op = MDU_OP_MTHI; rs = 32'd5; #1;
    n = 0;
    while (stall === 1'b1 && n < 60) begin @(negedge clk); n++; end
    check("mthi_wait_bound", 64'(n < 60), 64'd1);
    @(negedge clk);
    en = 1'b0; op = MDU_OP_NOP; #1;
    check("mthi_hi", 64'(hi), 64'd5);
    check("mthi_lo", 64'(lo), 64'd14);
    m_hi = 32'd5; m_lo = 32'd14;

    // Unknown and non-MDU ops never stall
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    exp = ref_result(MDU_OP_MULU, a, b);
    issue(MDU_OP_MULU, a, b);
    en = 1'b1; op = 4'hB; rs = 32'd123; #1;
    check("unk_stall", 64'(stall), 64'd0);
    check("unk_rd", 64'(rd), 64'd0);
    op = MDU_OP_NOP; #1;
    check("nop_stall", 64'(stall), 64'd0);
    check("nop_rd", 64'(rd), 64'd0);
    op = MDU_OP_MFHI; #1;
    check("mfhi_busy_stall", 64'(stall), 64'd1);
    en = 1'b0; op = MDU_OP_NOP;
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    check("unk_done_bound", 64'(n < 60), 64'd1);
    check("unk_hi", 64'(hi), 64'(exp[63:32]));
    check("unk_lo", 64'(lo), 64'(exp[31:0]));
    m_hi = exp[63:32]; m_lo = exp[31:0];
    en = 1'b1; op = 4'hC; rs = 32'hDEAD; @(negedge clk);
    en = 1'b0; op = MDU_OP_NOP; #1;
    check("unk_idle_busy", 64'(busy), 64'd0);
    check("unk_idle_hi", 64'(hi), 64'(m_hi));
    check("unk_idle_lo", 64'(lo), 64'(m_lo));

    // Flush mid-multiply
    issue(MDU_OP_MUL, 32'h0000_0F0F, 32'h0000_1111);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; #1;
    check("flush_busy", 64'(busy), 64'd0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) n++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(n), 64'd0);
    check("flush_hi", 64'(hi), 64'(m_hi));
    check("flush_lo", 64'(lo), 64'(m_lo));
    en = 1'b1; op = MDU_OP_MUL; rs = 32'd3; rt = 32'd4; flush = 1'b1;
    @(negedge clk);
    en = 1'b0; op = MDU_OP_NOP; flush = 1'b0; #1;
    check("flush_accept_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("flush_accept_busy2", 64'(busy), 64'd0);

    // Randomised mix; consecutive iterative ops run back-to-back
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      sel = $urandom_range(0, 7);
      case (sel)
        0: run_iter(MDU_OP_MUL, a, b);
        1: run_iter(MDU_OP_MULU, a, b);
        2: run_iter(MDU_OP_DIV, a, b);
        3: run_iter(MDU_OP_DIVU, a, b);
        4: begin issue(MDU_OP_MTHI, a, b); m_hi = a; check("rand_mthi", 64'(hi), 64'(m_hi)); end
        5: begin issue(MDU_OP_MTLO, a, b); m_lo = a; check("rand_mtlo", 64'(lo), 64'(m_lo)); end
        6: begin
          en = 1'b1; op = MDU_OP_MFHI; #1;
          check("rand_mfhi", 64'(rd), 64'(m_hi));
          en = 1'b0; op = MDU_OP_NOP; @(negedge clk);
        end
        default: begin
          en = 1'b1; op = MDU_OP_MFLO; #1;
          check("rand_mflo", 64'(rd), 64'(m_lo));
          en = 1'b0; op = MDU_OP_NOP; @(negedge clk);
        end
      endcase
    end

    // Asynchronous reset mid-operation
    run_iter(MDU_OP_MULU, 32'h0001_0001, 32'h0003_0000);
    issue(MDU_OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_rd", 64'(rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Multi-cycle multiply/divide unit that owns the HI/LO register pair. It is the sequential producer side of the HI/LO interface, sitting beside the combinational execute-stage ALU. The decode/execute stage issues MUL/MULU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO to it and receives a stall request while an iterative operation is in flight.

## Interface
- `DATA_WIDTH`, default 32: operand and HI/LO width; even, at least 8.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  issue valid from the execute stage.
- `op`  in  `MDU_OP_WIDTH`  operation code from `defines.v`.
- `flush`  in  1  aborts any in-flight operation (pipeline flush or exception).
- `rs`  in  `DATA_BUS`  operand A, the dividend or multiplicand.
- `rt`  in  `DATA_BUS`  operand B, the divisor or multiplier.
- `rd`  out  `DATA_BUS`  MFHI/MFLO read data; combinational; 0 otherwise.
- `stall`  out  1  the issuing stage must hold the current op.
- `busy`  out  1  an iterative operation is in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold a new mul/div result.
- `hi`, `lo`  out  `DATA_BUS` each  architectural HI and LO, registered.

## Operation
- FSM states: IDLE, RUN, FIX.
- **Accept:** in IDLE with `en`, no `flush`, and op in {MUL, MULU, DIV, DIVU}:
  - latch operand magnitudes, result signs, the op and zero-divisor flag;
  - load the iteration counter with DATA_WIDTH; go to RUN.
- **RUN:** one radix-2 step per cycle.
  - Multiply: shift-add into a 2·DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements each cycle; go to FIX when it reaches 0.
- **FIX:** apply sign correction, write HI/LO, go to IDLE.
  - Signed multiply: negate the 2W product if the operand signs differ.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - LO = low half or quotient; HI = high half or remainder.
- **Divide by zero** (DIV and DIVU): LO = all ones, HI = `rs` as issued.
- **Overflow case:** DIV of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no trap.
- **MTHI/MTLO:** in IDLE, write HI or LO from `rs` at the edge. Single cycle, no `done` pulse.
- **MFHI/MFLO:** in IDLE, `rd` = `hi` / `lo` combinationally.
- `rd` = 0 when `en` = 0, when `stall` = 1, or for any other op.
- `stall` = `busy` & `en` & (op is any of the 8 MDU ops). Non-MDU ops never stall.
- **`flush`:** from any state, go to IDLE at the next edge.
  - HI/LO are not written; no `done` pulse.
  - A flush coinciding with an accept wins, so nothing is accepted.
- Unknown op codes are ignored: no state change.

## Timing
- **Reset values:** `hi` = `lo` = 0, `busy` = 0, `done` = 0, `stall` = 0, `rd` = 0; FSM in IDLE.
- **Reset mid-operation:** the operation is discarded and HI/LO clear to 0.
- **Latency** (accept at edge 0):
  - `busy` = 1 in cycles 1 through DATA_WIDTH+1 (RUN ×DATA_WIDTH, then FIX ×1);
  - the new HI/LO are visible and `done` = 1 in cycle DATA_WIDTH+2 (cycle 34 at 32 bits), with `busy` = 0.
- **Back-to-back:** a new op may be accepted at the edge ending cycle DATA_WIDTH+2. There is no dead cycle.
- **MFHI issued during `busy`:** stalls until IDLE. In the `done` cycle `rd` already returns the new value; there is no bypass from FIX.
- **MTHI/MTLO issued during `busy`:** stalls, then writes after the result lands, so program order is preserved.
- `done` and `busy` are registered; `stall` and `rd` are combinational from registered state plus `en`/`op`.

## Structure
- **Additions to the shared `defines.v`:**
  - `MDU_OP_WIDTH`, `MDU_OP_NOP`, `MDU_OP_MUL`, `MDU_OP_MULU`, `MDU_OP_DIV`, `MDU_OP_DIVU`, `MDU_OP_MTHI`, `MDU_OP_MTLO`, `MDU_OP_MFHI`, `MDU_OP_MFLO`;
  - FSM state encodings `MDU_ST_IDLE`, `MDU_ST_RUN`, `MDU_ST_FIX`.
- **One sub-module, `shift_subtract_step`:**
  - purely combinational, one restoring-divide iteration (partial remainder, quotient bit);
  - instantiated once inside the RUN datapath.
- The multiply step stays inline; it is a single conditional add.

## Test plan
- **MUL:** `rs` = 0xFFFFFFFD (−3), `rt` = 7 → cycle 34: `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB, `done` = 1 for exactly one cycle.
- **MULU:** 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001. **DIV:** −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- **Divide edge cases:**
  - DIVU 7 / 0 → `lo` = 0xFFFFFFFF, `hi` = 7;
  - DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- **Hazard ordering:**
  - DIV 100 / 7, then MFLO at cycle 2 → `stall` = 1 through cycle 33, `rd` = 14 in cycle 34;
  - MTHI 5 issued during `busy` → `hi` = 5 after the divide completes.
- **Abort:**
  - `flush` at cycle 10 of a MUL → `busy` = 0 at cycle 11, HI/LO keep their prior values, no `done`;
  - `rst_n` low at cycle 20 → all outputs 0 immediately (asynchronous).
- **Non-stall and unknown ops:**
  - an unknown op and a non-MDU op during `busy` → `stall` = 0, `rd` = 0;
  - after reset, MFHI → `rd` = 0.
